multicycle_control_fsm: RTL and testbench
=========================================

Name: multicycle_control_fsm

Overview:
- Parametrised multi-cycle control unit for the RV32I core.
- Replaces single-cycle control sequencing with a FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK state machine.
- Drives the pc, instruction register, register file, ALU operand and memory strobes.
- Adds memory wait-state handshaking, bus timeout, halt request, illegal-opcode trap and a retired-instruction counter.

Parameters:
- MEM_TIMEOUT, default 15: maximum wait cycles for mem_ready before a timeout trap. 0 disables the timeout.
- TMO_W, default 4: width of the wait counter. Must satisfy MEM_TIMEOUT < 2**TMO_W.
- CNT_W, default 32: width of the instret counter.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- opcode  input  7  instruction[6:0] from the instruction register.
- branch_taken  input  1  branch comparison result for the current instruction.
- mem_ready  input  1  memory handshake: the access completes in the cycle this is high.
- halt_req  input  1  request to stop at the next instruction boundary.
- pc_write  output  1  pc register load enable.
- pc_src  output  2  next-pc select: 0 = pc+4, 1 = ALU target.
- ir_write  output  1  instruction register load enable.
- addr_src  output  1  memory address select: 0 = pc, 1 = ALU result.
- mem_read  output  1  memory read strobe.
- mem_write  output  1  memory write strobe.
- reg_write  output  1  register file write enable.
- result_src  output  2  rd value select: 0 = ALU, 1 = memory, 2 = pc+4, 3 = immediate.
- alu_a_src  output  2  ALU operand A select: 0 = rs1, 1 = pc, 2 = zero.
- alu_b_src  output  1  ALU operand B select: 0 = rs2, 1 = immediate.
- retire  output  1  one-cycle pulse when an instruction completes.
- instret  output  CNT_W  retired-instruction count.
- state  output  4  current state encoding.
- halted  output  1  high while in HALT.
- trap  output  1  sticky trap flag.
- trap_cause  output  2  trap reason: 0 = none, 1 = illegal opcode, 2 = fetch timeout, 3 = data timeout.

Behaviour:
- State encodings: FETCH = 0, DECODE = 1, EXECUTE = 2, MEMORY = 3, WRITEBACK = 4, HALT = 5, TRAP = 6.
- Reset (reset low, asynchronous): state = FETCH, wait counter = 0, instret = 0, trap = 0, trap_cause = 0.
- Strobe outputs are decoded combinationally from state, latched opcode and inputs. Every strobe not listed for a state is 0.
- FETCH:
  - mem_read = 1, addr_src = 0.
  - On mem_ready: ir_write = 1, go to DECODE.
  - Otherwise increment the wait counter.
- DECODE (1 cycle):
  - Latch opcode.
  - Legal opcodes: 0110111 (LUI), 0010111 (AUIPC), 1101111 (JAL), 1100111 (JALR), 1100011 (BRANCH), 0000011 (LOAD), 0100011 (STORE), 0010011 (OP-IMM), 0110011 (OP).
  - Legal opcode: go to EXECUTE. Any other opcode: go to TRAP with cause 1.
- EXECUTE (1 cycle):
  - OP: alu_a_src = 0, alu_b_src = 0, go to WRITEBACK.
  - OP-IMM, LOAD, STORE, JALR: alu_a_src = 0, alu_b_src = 1.
  - AUIPC, JAL, BRANCH: alu_a_src = 1, alu_b_src = 1.
  - LUI: alu_a_src = 2, alu_b_src = 1.
  - OP-IMM, LUI, AUIPC, JAL, JALR: go to WRITEBACK.
  - LOAD, STORE: go to MEMORY.
  - BRANCH: pc_write = 1, pc_src = branch_taken, retire = 1, go to FETCH (or HALT).
- MEMORY:
  - addr_src = 1; mem_read = 1 for LOAD, mem_write = 1 for STORE.
  - Strobes are held until mem_ready.
  - On mem_ready, STORE: pc_write = 1, pc_src = 0, retire = 1, go to FETCH (or HALT).
  - On mem_ready, LOAD: go to WRITEBACK.
- WRITEBACK (1 cycle):
  - reg_write = 1, pc_write = 1, retire = 1.
  - result_src: 1 for LOAD, 2 for JAL/JALR, 0 otherwise (LUI uses ALU with zero operand).
  - pc_src = 1 for JAL/JALR, 0 otherwise.
  - Go to FETCH (or HALT).
- Instruction boundary (any transition that would enter FETCH):
  - If halt_req = 1 at that clock edge, enter HALT instead.
  - HALT: all strobes 0, halted = 1. Leave to FETCH on the first cycle halt_req = 0.
  - halt_req has no effect mid-instruction.
- Wait counter:
  - Cleared on entry to FETCH or MEMORY and whenever mem_ready = 1.
  - If MEM_TIMEOUT != 0 and the counter equals MEM_TIMEOUT while mem_ready = 0: go to TRAP, cause 2 (FETCH) or 3 (MEMORY).
  - mem_ready in the same cycle as the limit is reached wins: no trap.
- TRAP:
  - All strobes 0, trap = 1, trap_cause held.
  - Exited only by reset; ignores halt_req.
- instret:
  - Increments by 1 on every retire pulse and wraps modulo 2**CNT_W.
  - Trapped instructions do not retire.
- Reset asserted mid-instruction aborts immediately: no pc_write, reg_write or mem_write on the following edge.

Test Plan:
- OP instruction, mem_ready = 1 every cycle -> state sequence 0, 1, 2, 4, 0. retire = 1 and reg_write = 1 in WRITEBACK, result_src = 0. instret goes 0 -> 1.
- LOAD with mem_ready delayed 3 cycles in MEMORY -> mem_read held high for 4 cycles, then WRITEBACK with result_src = 1. Total 8 cycles from FETCH to the next FETCH.
- BRANCH with branch_taken = 1, then with branch_taken = 0 -> EXECUTE asserts pc_write with pc_src = 1, then pc_src = 0. No reg_write. 3 cycles per instruction.
- opcode = 7'b1111111 -> TRAP after DECODE with trap_cause = 1. Strobes stay 0 for 20 cycles. instret unchanged. Reset low then high returns to FETCH with trap = 0.
- MEM_TIMEOUT = 15, mem_ready held 0 in FETCH -> TRAP with cause 2 after 15 wait cycles. Repeating with mem_ready = 1 exactly at wait count 15 -> no trap.
- halt_req raised during MEMORY of a STORE -> the store completes (mem_write, pc_write, retire), then HALT with halted = 1. Dropping halt_req -> FETCH next cycle. Set CNT_W = 2 and retire 5 instructions -> instret = 1.

Source files
------------

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RV32I control sequencer: FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK with
// memory wait states, bus timeout, halt at instruction boundaries and sticky traps.
module multicycle_control_fsm #(
    parameter int MEM_TIMEOUT = 15,
    parameter int TMO_W       = 4,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       opcode,
    input  logic             branch_taken,
    input  logic             mem_ready,
    input  logic             halt_req,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic             ir_write,
    output logic             addr_src,
    output logic             mem_read,
    output logic             mem_write,
    output logic             reg_write,
    output logic [1:0]       result_src,
    output logic [1:0]       alu_a_src,
    output logic             alu_b_src,
    output logic             retire,
    output logic [CNT_W-1:0] instret,
    output logic [3:0]       state,
    output logic             halted,
    output logic             trap,
    output logic [1:0]       trap_cause
);

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_EXECUTE   = 4'd2,
        S_MEMORY    = 4'd3,
        S_WRITEBACK = 4'd4,
        S_HALT      = 4'd5,
        S_TRAP      = 4'd6
    } state_t;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam bit             TMO_EN  = (MEM_TIMEOUT != 0);
    localparam logic [TMO_W-1:0] TMO_LIM = TMO_W'(MEM_TIMEOUT);

    state_t           cur, nxt;
    logic [TMO_W-1:0] wait_cnt;
    logic [6:0]       op_q;
    logic             trap_q;
    logic [1:0]       cause_q;
    logic             trap_set;
    logic [1:0]       cause_nxt;
    logic             legal;
    logic             tmo_hit;
    state_t           boundary;

    always_comb begin
        legal = opcode inside {OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH,
                               OPC_LOAD, OPC_STORE, OPC_OPIMM, OPC_OP};
    end

    // mem_ready in the limit cycle takes priority, so the hit is qualified with !mem_ready
    assign tmo_hit  = TMO_EN && (wait_cnt == TMO_LIM) && !mem_ready;
    assign boundary = halt_req ? S_HALT : S_FETCH;

    always_comb begin
        nxt        = cur;
        pc_write   = 1'b0;
        pc_src     = 2'd0;
        ir_write   = 1'b0;
        addr_src   = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        result_src = 2'd0;
        alu_a_src  = 2'd0;
        alu_b_src  = 1'b0;
        retire     = 1'b0;
        halted     = 1'b0;
        trap_set   = 1'b0;
        cause_nxt  = cause_q;

        case (cur)
            S_FETCH: begin
                mem_read = 1'b1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    nxt      = S_DECODE;
                end else if (tmo_hit) begin
                    nxt       = S_TRAP;
                    trap_set  = 1'b1;
                    cause_nxt = 2'd2;
                end
            end

            S_DECODE: begin
                if (legal) begin
                    nxt = S_EXECUTE;
                end else begin
                    nxt       = S_TRAP;
                    trap_set  = 1'b1;
                    cause_nxt = 2'd1;
                end
            end

            S_EXECUTE: begin
                case (op_q)
                    OPC_OP: begin
                        nxt = S_WRITEBACK;
                    end
                    OPC_OPIMM, OPC_JALR: begin
                        alu_b_src = 1'b1;
                        nxt       = S_WRITEBACK;
                    end
                    OPC_LOAD, OPC_STORE: begin
                        alu_b_src = 1'b1;
                        nxt       = S_MEMORY;
                    end
                    OPC_AUIPC, OPC_JAL: begin
                        alu_a_src = 2'd1;
                        alu_b_src = 1'b1;
                        nxt       = S_WRITEBACK;
                    end
                    OPC_BRANCH: begin
                        alu_a_src = 2'd1;
                        alu_b_src = 1'b1;
                        pc_write  = 1'b1;
                        pc_src    = {1'b0, branch_taken};
                        retire    = 1'b1;
                        nxt       = boundary;
                    end
                    OPC_LUI: begin
                        alu_a_src = 2'd2;
                        alu_b_src = 1'b1;
                        nxt       = S_WRITEBACK;
                    end
                    default: nxt = S_FETCH;
                endcase
            end

            S_MEMORY: begin
                addr_src  = 1'b1;
                mem_read  = (op_q == OPC_LOAD);
                mem_write = (op_q == OPC_STORE);
                if (mem_ready) begin
                    if (op_q == OPC_STORE) begin
                        pc_write = 1'b1;
                        retire   = 1'b1;
                        nxt      = boundary;
                    end else begin
                        nxt = S_WRITEBACK;
                    end
                end else if (tmo_hit) begin
                    nxt       = S_TRAP;
                    trap_set  = 1'b1;
                    cause_nxt = 2'd3;
                end
            end

            S_WRITEBACK: begin
                reg_write = 1'b1;
                pc_write  = 1'b1;
                retire    = 1'b1;
                if (op_q == OPC_LOAD) begin
                    result_src = 2'd1;
                end else if (op_q == OPC_JAL || op_q == OPC_JALR) begin
                    result_src = 2'd2;
                    pc_src     = 2'd1;
                end
                nxt = boundary;
            end

            S_HALT: begin
                halted = 1'b1;
                if (!halt_req) nxt = S_FETCH;
            end

            S_TRAP: begin
                nxt = S_TRAP;
            end

            default: nxt = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur      <= S_FETCH;
            wait_cnt <= '0;
            op_q     <= '0;
            instret  <= '0;
            trap_q   <= 1'b0;
            cause_q  <= 2'd0;
        end else begin
            cur <= nxt;
            // Counter restarts on every state change so it only measures the current access
            if (nxt != cur || mem_ready) begin
                wait_cnt <= '0;
            end else if (cur == S_FETCH || cur == S_MEMORY) begin
                wait_cnt <= wait_cnt + TMO_W'(1);
            end
            if (cur == S_DECODE) op_q <= opcode;
            if (retire) instret <= instret + CNT_W'(1);
            if (trap_set) begin
                trap_q  <= 1'b1;
                cause_q <= cause_nxt;
            end
        end
    end

    assign state      = cur;
    assign trap       = trap_q;
    assign trap_cause = cause_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm: vector table for instruction flows,
// hand sequences for traps, timeouts, reset abort and counter wrap.
module tb_multicycle_control_fsm;

    localparam logic [6:0] OP    = 7'b0110011;
    localparam logic [6:0] LOAD  = 7'b0000011;
    localparam logic [6:0] STORE = 7'b0100011;
    localparam logic [6:0] BR    = 7'b1100011;
    localparam logic [6:0] JAL   = 7'b1101111;
    localparam logic [6:0] JALR  = 7'b1100111;
    localparam logic [6:0] LUI   = 7'b0110111;
    localparam logic [6:0] ILL   = 7'b1111111;

    logic        clk, reset;
    logic [6:0]  opcode;
    logic        branch_taken, mem_ready, halt_req;
    logic        pc_write, ir_write, addr_src, mem_read, mem_write, reg_write;
    logic        alu_b_src, retire, halted, trap;
    logic [1:0]  pc_src, result_src, alu_a_src, trap_cause;
    logic [31:0] instret;
    logic [3:0]  state;

    logic        s_pc_write, s_ir_write, s_addr_src, s_mem_read, s_mem_write, s_reg_write;
    logic        s_alu_b_src, s_retire, s_halted, s_trap;
    logic [1:0]  s_pc_src, s_result_src, s_alu_a_src, s_trap_cause;
    logic [1:0]  s_instret;
    logic [3:0]  s_state;

    multicycle_control_fsm dut (
        .clk(clk), .reset(reset), .opcode(opcode), .branch_taken(branch_taken),
        .mem_ready(mem_ready), .halt_req(halt_req), .pc_write(pc_write), .pc_src(pc_src),
        .ir_write(ir_write), .addr_src(addr_src), .mem_read(mem_read), .mem_write(mem_write),
        .reg_write(reg_write), .result_src(result_src), .alu_a_src(alu_a_src),
        .alu_b_src(alu_b_src), .retire(retire), .instret(instret), .state(state),
        .halted(halted), .trap(trap), .trap_cause(trap_cause)
    );

    multicycle_control_fsm #(.CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .opcode(opcode), .branch_taken(branch_taken),
        .mem_ready(mem_ready), .halt_req(halt_req), .pc_write(s_pc_write), .pc_src(s_pc_src),
        .ir_write(s_ir_write), .addr_src(s_addr_src), .mem_read(s_mem_read),
        .mem_write(s_mem_write), .reg_write(s_reg_write), .result_src(s_result_src),
        .alu_a_src(s_alu_a_src), .alu_b_src(s_alu_b_src), .retire(s_retire),
        .instret(s_instret), .state(s_state), .halted(s_halted), .trap(s_trap),
        .trap_cause(s_trap_cause)
    );

    logic [19:0] act;
    assign act = {state, pc_write, pc_src, ir_write, addr_src, mem_read, mem_write,
                  reg_write, result_src, alu_a_src, alu_b_src, retire, halted, trap};

    typedef struct {
        logic [6:0]  op;
        logic        bt;
        logic        rdy;
        logic        hlt;
        logic [19:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_err = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Field order: state, pc_write, pc_src, ir_write, addr_src, mem_read, mem_write,
    // reg_write, result_src, alu_a_src, alu_b_src, retire, halted (trap appended as 0)
    function automatic logic [19:0] ex(int st, int pcw, int pcs, int irw, int as, int mr,
                                       int mw, int rw, int rs, int aa, int ab, int rt, int hl);
        return {4'(st), 1'(pcw), 2'(pcs), 1'(irw), 1'(as), 1'(mr), 1'(mw), 1'(rw),
                2'(rs), 2'(aa), 1'(ab), 1'(rt), 1'(hl), 1'b0};
    endfunction

    task automatic add(logic [6:0] op, logic bt, logic rdy, logic hlt, logic [19:0] e);
        vec_t v;
        v.op = op; v.bt = bt; v.rdy = rdy; v.hlt = hlt; v.exp = e;
        vecs.push_back(v);
    endtask

    task automatic chk(string name, logic [31:0] a, logic [31:0] e);
        n_vec++;
        if (a !== e) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, a, e);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(logic [6:0] op, logic bt, logic rdy, logic hlt);
        opcode = op; branch_taken = bt; mem_ready = rdy; halt_req = hlt;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0;
        drive(OP, 1'b0, 1'b1, 1'b0);

        // OP
        add(OP,   0, 1, 0, ex(0, 0,0, 1,0,1,0, 0,0, 0,0, 0,0));
        add(OP,   0, 1, 0, ex(1, 0,0, 0,0,0,0, 0,0, 0,0, 0,0));
        add(OP,   0, 1, 0, ex(2, 0,0, 0,0,0,0, 0,0, 0,0, 0,0));
        add(OP,   0, 1, 0, ex(4, 1,0, 0,0,0,0, 1,0, 0,0, 1,0));
        // LOAD, three wait states
        add(LOAD, 0, 1, 0, ex(0, 0,0, 1,0,1,0, 0,0, 0,0, 0,0));
        add(LOAD, 0, 1, 0, ex(1, 0,0, 0,0,0,0, 0,0, 0,0, 0,0));
        add(LOAD, 0, 1, 0, ex(2, 0,0, 0,0,0,0, 0,0, 0,1, 0,0));
        add(LOAD, 0, 0, 0, ex(3, 0,0, 0,1,1,0, 0,0, 0,0, 0,0));
        add(LOAD, 0, 0, 0, ex(3, 0,0, 0,1,1,0, 0,0, 0,0, 0,0));
        add(LOAD, 0, 0, 0, ex(3, 0,0, 0,1,1,0, 0,0, 0,0, 0,0));
        add(LOAD, 0, 1, 0, ex(3, 0,0, 0,1,1,0, 0,0, 0,0, 0,0));
        add(LOAD, 0, 1, 0, ex(4, 1,0, 0,0,0,0, 1,1, 0,0, 1,0));
        // BRANCH taken / not taken
        add(BR,   1, 1, 0, ex(0, 0,0, 1,0,1,0, 0,0, 0,0, 0,0));
        add(BR,   1, 1, 0, ex(1, 0,0, 0,0,0,0, 0,0, 0,0, 0,0));
        add(BR,   1, 1, 0, ex(2, 1,1, 0,0,0,0, 0,0, 1,1, 1,0));
        add(BR,   0, 1, 0, ex(0, 0,0, 1,0,1,0, 0,0, 0,0, 0,0));
        add(BR,   0, 1, 0, ex(1, 0,0, 0,0,0,0, 0,0, 0,0, 0,0));
        add(BR,   0, 1, 0, ex(2, 1,0, 0,0,0,0, 0,0, 1,1, 1,0));
        // JAL
        add(JAL,  0, 1, 0, ex(0, 0,0, 1,0,1,0, 0,0, 0,0, 0,0));
        add(JAL,  0, 1, 0, ex(1, 0,0, 0,0,0,0, 0,0, 0,0, 0,0));
        add(JAL,  0, 1, 0, ex(2, 0,0, 0,0,0,0, 0,0, 1,1, 0,0));
        add(JAL,  0, 1, 0, ex(4, 1,1, 0,0,0,0, 1,2, 0,0, 1,0));
        // LUI
        add(LUI,  0, 1, 0, ex(0, 0,0, 1,0,1,0, 0,0, 0,0, 0,0));
        add(LUI,  0, 1, 0, ex(1, 0,0, 0,0,0,0, 0,0, 0,0, 0,0));
        add(LUI,  0, 1, 0, ex(2, 0,0, 0,0,0,0, 0,0, 2,1, 0,0));
        add(LUI,  0, 1, 0, ex(4, 1,0, 0,0,0,0, 1,0, 0,0, 1,0));
        // STORE with halt raised in MEMORY
        add(STORE,0, 1, 0, ex(0, 0,0, 1,0,1,0, 0,0, 0,0, 0,0));
        add(STORE,0, 1, 0, ex(1, 0,0, 0,0,0,0, 0,0, 0,0, 0,0));
        add(STORE,0, 1, 0, ex(2, 0,0, 0,0,0,0, 0,0, 0,1, 0,0));
        add(STORE,0, 0, 1, ex(3, 0,0, 0,1,0,1, 0,0, 0,0, 0,0));
        add(STORE,0, 1, 1, ex(3, 1,0, 0,1,0,1, 0,0, 0,0, 1,0));
        add(STORE,0, 1, 1, ex(5, 0,0, 0,0,0,0, 0,0, 0,0, 0,1));
        add(STORE,0, 1, 0, ex(5, 0,0, 0,0,0,0, 0,0, 0,0, 0,1));
        // JALR: halt ignored mid-instruction, honoured at WRITEBACK
        add(JALR, 0, 1, 0, ex(0, 0,0, 1,0,1,0, 0,0, 0,0, 0,0));
        add(JALR, 0, 1, 1, ex(1, 0,0, 0,0,0,0, 0,0, 0,0, 0,0));
        add(JALR, 0, 1, 1, ex(2, 0,0, 0,0,0,0, 0,0, 0,1, 0,0));
        add(JALR, 0, 1, 1, ex(4, 1,1, 0,0,0,0, 1,2, 0,0, 1,0));
        add(JALR, 0, 1, 0, ex(5, 0,0, 0,0,0,0, 0,0, 0,0, 0,1));
        add(OP,   0, 0, 0, ex(0, 0,0, 0,0,1,0, 0,0, 0,0, 0,0));

        // Reset state, sampled while reset is held low
        @(negedge clk);
        #1;
        chk("reset_state", {28'd0, state}, 32'd0);
        chk("reset_instret", instret, 32'd0);
        chk("reset_trap", {29'd0, trap, trap_cause}, 32'd0);
        reset = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i].op, vecs[i].bt, vecs[i].rdy, vecs[i].hlt);
            #1;
            chk($sformatf("vec%0d", i), {12'd0, act}, {12'd0, vecs[i].exp});
            step();
        end
        chk("table_instret", instret, 32'd8);

        // Illegal opcode -> sticky trap, strobes quiet
        do_reset();
        drive(ILL, 1'b0, 1'b1, 1'b0);
        step();
        step();
        chk("ill_cause", {28'd0, trap, 1'b0, trap_cause}, {28'd0, 1'b1, 1'b0, 2'd1});
        for (int c = 0; c < 20; c++) begin
            drive(OP, 1'b1, 1'b1, c[0]);
            #1;
            chk("ill_quiet", {12'd0, act}, {12'd0, ex(6, 0,0, 0,0,0,0, 0,0, 0,0, 0,0) | 20'd1});
            step();
        end
        chk("ill_instret", instret, 32'd0);
        reset = 1'b0;
        #1;
        chk("ill_reset", {27'd0, state, trap}, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Fetch timeout: 15 wait cycles tolerated, trap on the 16th edge
        drive(OP, 1'b0, 1'b0, 1'b0);
        for (int c = 0; c < 15; c++) step();
        chk("tmo_f_pre", {28'd0, state}, 32'd0);
        step();
        chk("tmo_f_trap", {26'd0, state, trap_cause}, {26'd0, 4'd6, 2'd2});

        // Ready exactly at the limit wins
        do_reset();
        drive(LOAD, 1'b0, 1'b0, 1'b0);
        for (int c = 0; c < 15; c++) step();
        mem_ready = 1'b1;
        step();
        chk("tmo_f_edge", {27'd0, state, trap}, {27'd0, 4'd1, 1'b0});

        // Data timeout in MEMORY
        step();
        step();
        mem_ready = 1'b0;
        chk("tmo_d_mem", {28'd0, state}, 32'd3);
        for (int c = 0; c < 15; c++) step();
        chk("tmo_d_pre", {28'd0, state}, 32'd3);
        step();
        chk("tmo_d_trap", {26'd0, state, trap_cause}, {26'd0, 4'd6, 2'd3});

        // Reset during WRITEBACK aborts the write
        do_reset();
        drive(OP, 1'b0, 1'b1, 1'b0);
        step(); step(); step();
        #1;
        chk("abort_wb", {29'd0, state[2], pc_write, reg_write}, {29'd0, 3'b111});
        reset = 1'b0;
        #1;
        chk("abort_now", {25'd0, state, pc_write, reg_write, mem_write}, 32'd0);
        @(posedge clk);
        #1;
        chk("abort_instret", instret, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Five retirements: 2-bit counter wraps to 1
        drive(OP, 1'b0, 1'b1, 1'b0);
        for (int c = 0; c < 20; c++) step();
        chk("wrap_narrow", {30'd0, s_instret}, 32'd1);
        chk("wrap_wide", instret, 32'd5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
